// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester and memory-port signal bundle for mem_access_arbiter
interface mem_access_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req0;
   logic              rw0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              req1;
   logic              rw1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [1:0]        grant;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_EN;
   logic              mem_RW;
   logic [DATA_W-1:0] mem_rdata;
   logic              MFC;

   modport slave (
      input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_rdata, MFC,
      output ack0, ack1, grant, rdata, err, busy, mem_addr, mem_wdata, mem_EN, mem_RW
   );

   modport master (
      output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_rdata, MFC,
      input  ack0, ack1, grant, rdata, err, busy, mem_addr, mem_wdata, mem_EN, mem_RW
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin arbiter sharing one MFC-handshake memory port between fetch and load/store
module mem_access_arbiter #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 16
) (
   input logic                clk,
   input logic                rst,
   mem_access_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, GAP} state_t;

   state_t           state;
   logic             last_grant;
   logic             owner;
   logic [CNT_W-1:0] cnt;
   logic             any_req;
   logic             sel;
   logic             timeout_hit;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      any_req = bus.req0 | bus.req1;
      if (bus.req0 && bus.req1) begin
         sel = ~last_grant;
      end else begin
         sel = bus.req1;
      end
      timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         owner         <= 1'b0;
         cnt           <= '0;
         bus.ack0      <= 1'b0;
         bus.ack1      <= 1'b0;
         bus.grant     <= 2'b00;
         bus.rdata     <= '0;
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_EN    <= 1'b0;
         bus.mem_RW    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner         <= sel;
                  last_grant    <= sel;
                  bus.grant     <= sel ? 2'b10 : 2'b01;
                  bus.mem_addr  <= sel ? bus.addr1 : bus.addr0;
                  bus.mem_wdata <= sel ? bus.wdata1 : bus.wdata0;
                  bus.mem_RW    <= sel ? bus.rw1 : bus.rw0;
                  cnt           <= '0;
                  bus.mem_EN    <= 1'b1;
                  bus.busy      <= 1'b1;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               cnt <= cnt + CNT_W'(1);
               // MFC wins over the timeout when both land in the last allowed cycle.
               if (bus.MFC || timeout_hit) begin
                  bus.mem_EN <= 1'b0;
                  bus.err    <= ~bus.MFC;
                  bus.ack0   <= ~owner;
                  bus.ack1   <= owner;
                  state      <= DONE;
                  if (bus.MFC && bus.mem_RW) begin
                     bus.rdata <= bus.mem_rdata;
                  end
               end
            end
            DONE: begin
               bus.ack0   <= 1'b0;
               bus.ack1   <= 1'b0;
               bus.err    <= 1'b0;
               bus.grant  <= 2'b00;
               bus.mem_RW <= 1'b0;
               state      <= GAP;
            end
            GAP: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - randomized self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [15:0] model_rdata = '0;

   mem_access_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   mem_access_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic int exp_en(input int mfc_at);
      return (mfc_at >= 1 && mfc_at <= TO) ? mfc_at : TO;
   endfunction

   function automatic bit exp_err(input int mfc_at);
      return !(mfc_at >= 1 && mfc_at <= TO);
   endfunction

   task automatic do_txn(input int id, input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                         input int mfc_at, input logic [15:0] rd,
                         output int lat, output int en_cycles, output logic ack_ok, output logic err_o,
                         output logic [15:0] rdata_o, output logic [1:0] grant_done,
                         output logic hold_ok, output logic gap_ok);
      logic [1:0] g;
      g = (id == 0) ? 2'b01 : 2'b10;
      lat = 0; en_cycles = 0; hold_ok = 1'b1;
      if (id == 0) begin
         bus.req0 = 1'b1; bus.rw0 = rw; bus.addr0 = addr; bus.wdata0 = wd;
      end else begin
         bus.req1 = 1'b1; bus.rw1 = rw; bus.addr1 = addr; bus.wdata1 = wd;
      end
      while (!bus.mem_EN && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      while (bus.mem_EN && en_cycles < 40) begin
         en_cycles++;
         if (bus.mem_addr !== addr || bus.mem_RW !== rw || bus.mem_wdata !== wd ||
             bus.busy !== 1'b1 || bus.grant !== g || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0)
            hold_ok = 1'b0;
         bus.MFC = (en_cycles == mfc_at);
         bus.mem_rdata = (en_cycles == mfc_at) ? rd : 16'($urandom);
         @(negedge clk);
      end
      bus.MFC = 1'b0;
      ack_ok = (id == 0) ? (bus.ack0 === 1'b1 && bus.ack1 === 1'b0)
                         : (bus.ack1 === 1'b1 && bus.ack0 === 1'b0);
      err_o = bus.err;
      rdata_o = bus.rdata;
      grant_done = bus.grant;
      if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      @(negedge clk);
      gap_ok = (bus.ack0 === 1'b0 && bus.ack1 === 1'b0 && bus.err === 1'b0 &&
                bus.grant === 2'b00 && bus.busy === 1'b1 && bus.mem_EN === 1'b0 && bus.mem_RW === 1'b0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.req0 = 0; bus.rw0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
      bus.req1 = 0; bus.rw1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
      bus.mem_rdata = 0; bus.MFC = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.ack0, bus.ack1, bus.err, bus.busy, bus.mem_EN, bus.mem_RW, bus.grant} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000000",
                  {bus.ack0, bus.ack1, bus.err, bus.busy, bus.mem_EN, bus.mem_RW, bus.grant});
      end
      checks++;
      if (bus.rdata !== 16'h0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", bus.rdata, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b0;
      model_rdata = '0;
      @(negedge clk);
   endtask

   task automatic test_fetch_read();
      int lat, en; logic ack_ok, e, hold_ok, gap_ok; logic [15:0] rd; logic [1:0] g;
      do_txn(0, 1'b1, 16'h0010, 16'h0000, 3, 16'hBEEF, lat, en, ack_ok, e, rd, g, hold_ok, gap_ok);
      model_rdata = 16'hBEEF;
      checks++;
      if (lat !== 1 || en !== 3) begin
         errors++; $display("FAIL fetch_timing got lat=%0d en=%0d want lat=1 en=3", lat, en);
      end
      checks++;
      if ({ack_ok, hold_ok, gap_ok} !== 3'b111 || g !== 2'b01) begin
         errors++; $display("FAIL fetch_handshake got ack/hold/gap=%b grant=%b want 111 01", {ack_ok, hold_ok, gap_ok}, g);
      end
      checks++;
      if (e !== 1'b0 || rd !== model_rdata) begin
         errors++; $display("FAIL fetch_data got err=%b rdata=%h want 0 %h", e, rd, model_rdata);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL fetch_idle got busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_store();
      int lat, en; logic ack_ok, e, hold_ok, gap_ok; logic [15:0] rd; logic [1:0] g;
      do_txn(1, 1'b0, 16'h0042, 16'h1234, 2, 16'hDEAD, lat, en, ack_ok, e, rd, g, hold_ok, gap_ok);
      checks++;
      if (en !== 2 || {ack_ok, hold_ok, gap_ok} !== 3'b111 || g !== 2'b10) begin
         errors++; $display("FAIL store_handshake got en=%0d ack/hold/gap=%b grant=%b want 2 111 10", en, {ack_ok, hold_ok, gap_ok}, g);
      end
      checks++;
      if (e !== 1'b0 || rd !== model_rdata) begin
         errors++; $display("FAIL store_data got err=%b rdata=%h want 0 %h", e, rd, model_rdata);
      end
   endtask

   task automatic test_timeout();
      int lat, en; logic ack_ok, e, hold_ok, gap_ok; logic [15:0] rd; logic [1:0] g;
      do_txn(0, 1'b1, 16'h0100, 16'h0000, 0, 16'h7777, lat, en, ack_ok, e, rd, g, hold_ok, gap_ok);
      checks++;
      if (en !== TO || ack_ok !== 1'b1 || e !== 1'b1 || rd !== model_rdata) begin
         errors++; $display("FAIL timeout_err got en=%0d ack=%b err=%b rdata=%h want %0d 1 1 %h", en, ack_ok, e, rd, TO, model_rdata);
      end
      do_txn(0, 1'b1, 16'h0101, 16'h0000, TO, 16'h6666, lat, en, ack_ok, e, rd, g, hold_ok, gap_ok);
      model_rdata = 16'h6666;
      checks++;
      if (en !== TO || ack_ok !== 1'b1 || e !== 1'b0 || rd !== model_rdata) begin
         errors++; $display("FAIL timeout_last_mfc got en=%0d ack=%b err=%b rdata=%h want %0d 1 0 %h", en, ack_ok, e, rd, TO, model_rdata);
      end
   endtask

   task automatic test_contention();
      logic both; logic [1:0] want; int n;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
      both = 1'b0;
      bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 16'h0100;
      bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 16'h0200;
      for (int k = 0; k < 4; k++) begin
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         n = 0;
         while (!bus.mem_EN && n < 20) begin
            if (bus.grant === 2'b11) both = 1'b1;
            @(negedge clk);
            n++;
         end
         checks++;
         if (bus.grant !== want) begin
            errors++; $display("FAIL contention_grant%0d got %b want %b", k, bus.grant, want);
         end
         bus.MFC = 1'b1; bus.mem_rdata = 16'(k + 1);
         @(negedge clk);
         bus.MFC = 1'b0;
         model_rdata = 16'(k + 1);
         checks++;
         if ({bus.ack0, bus.ack1} !== {want[0], want[1]} || bus.rdata !== model_rdata) begin
            errors++; $display("FAIL contention_ack%0d got ack0/ack1=%b rdata=%h want %b %h", k, {bus.ack0, bus.ack1}, bus.rdata, {want[0], want[1]}, model_rdata);
         end
         if (bus.grant === 2'b11) both = 1'b1;
         if (want == 2'b01) bus.req0 = 1'b0; else bus.req1 = 1'b0;
         @(negedge clk);
         if (bus.grant === 2'b11) both = 1'b1;
         if (k < 3) begin
            if (want == 2'b01) bus.req0 = 1'b1; else bus.req1 = 1'b1;
         end
         @(negedge clk);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (both !== 1'b0) begin
         errors++; $display("FAIL contention_onehot got both-grant=%b want 0", both);
      end
   endtask

   task automatic test_reset_mid_access();
      int n;
      for (int id = 1; id >= 0; id--) begin
         if (id == 1) begin bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 16'h0300; end
         else begin bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 16'h0400; end
         n = 0;
         while (!bus.mem_EN && n < 20) begin @(negedge clk); n++; end
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         model_rdata = '0;
         checks++;
         if ({bus.mem_EN, bus.ack0, bus.ack1, bus.busy, bus.grant} !== 6'b0 || bus.rdata !== 16'h0) begin
            errors++; $display("FAIL rst_mid%0d got en/ack0/ack1/busy/grant=%b rdata=%h want 000000 0000", id, {bus.mem_EN, bus.ack0, bus.ack1, bus.busy, bus.grant}, bus.rdata);
         end
         rst = 1'b0;
         bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 16'h0500;
         bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 16'h0600;
         @(negedge clk);
         checks++;
         if (bus.grant !== 2'b01 || bus.mem_addr !== 16'h0500) begin
            errors++; $display("FAIL rst_first_tie%0d got grant=%b addr=%h want 01 0500", id, bus.grant, bus.mem_addr);
         end
         bus.MFC = 1'b1; bus.mem_rdata = 16'hA5A5;
         @(negedge clk);
         bus.MFC = 1'b0;
         model_rdata = 16'hA5A5;
         checks++;
         if (bus.ack0 !== 1'b1 || bus.rdata !== model_rdata) begin
            errors++; $display("FAIL rst_after_ack%0d got ack0=%b rdata=%h want 1 %h", id, bus.ack0, bus.rdata, model_rdata);
         end
         bus.req0 = 0; bus.req1 = 0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_late_arrival();
      int n, en;
      bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 16'h0030;
      n = 0;
      while (!bus.mem_EN && n < 20) begin @(negedge clk); n++; end
      bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 16'h0077;
      en = 0;
      while (bus.mem_EN && en < 40) begin
         en++;
         bus.MFC = (en == 2); bus.mem_rdata = 16'h3333;
         @(negedge clk);
      end
      bus.MFC = 1'b0;
      model_rdata = 16'h3333;
      checks++;
      if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.rdata !== model_rdata) begin
         errors++; $display("FAIL late_ack0 got ack0=%b ack1=%b rdata=%h want 1 0 %h", bus.ack0, bus.ack1, bus.rdata, model_rdata);
      end
      bus.req0 = 1'b0;
      n = 0;
      while (!(bus.mem_EN === 1'b1 && bus.grant === 2'b10) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n !== 3 || bus.mem_addr !== 16'h0077) begin
         errors++; $display("FAIL late_grant got delay=%0d addr=%h want 3 0077", n, bus.mem_addr);
      end
      bus.MFC = 1'b1; bus.mem_rdata = 16'h5555;
      @(negedge clk);
      bus.MFC = 1'b0;
      model_rdata = 16'h5555;
      checks++;
      if (bus.ack1 !== 1'b1 || bus.rdata !== model_rdata) begin
         errors++; $display("FAIL late_ack1 got ack1=%b rdata=%h want 1 %h", bus.ack1, bus.rdata, model_rdata);
      end
      bus.req1 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int lat, en, id, mfc_at; logic rw, ack_ok, e, hold_ok, gap_ok;
      logic [15:0] addr, wd, rdv, rd; logic [1:0] g;
      for (int i = 0; i < 24; i++) begin
         id = int'($urandom_range(0, 1));
         rw = 1'($urandom);
         addr = 16'($urandom);
         wd = 16'($urandom);
         rdv = 16'($urandom);
         mfc_at = int'($urandom_range(0, TO + 2));
         do_txn(id, rw, addr, wd, mfc_at, rdv, lat, en, ack_ok, e, rd, g, hold_ok, gap_ok);
         if (rw && !exp_err(mfc_at)) model_rdata = rdv;
         checks++;
         if (lat !== 1 || en !== exp_en(mfc_at) || e !== exp_err(mfc_at) || rd !== model_rdata) begin
            errors++; $display("FAIL random%0d got lat=%0d en=%0d err=%b rdata=%h want 1 %0d %b %h", i, lat, en, e, rd, exp_en(mfc_at), exp_err(mfc_at), model_rdata);
         end
         checks++;
         if ({ack_ok, hold_ok, gap_ok} !== 3'b111 || g !== ((id == 0) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL random_hs%0d got ack/hold/gap=%b grant=%b id=%0d want 111", i, {ack_ok, hold_ok, gap_ok}, g, id);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_store();
      test_timeout();
      test_contention();
      test_reset_mid_access();
      test_late_arrival();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
